data_memory_ctrl: RTL
=====================

Name: data_memory_ctrl

Overview:
Parametrised data-memory subsystem for the 24-bit microarchitecture. It replaces the fixed IO/main split with a configurable address map and gives both ports a uniform registered-read request/valid interface. It owns an internal main RAM array and a small IO register block with a switch/GPIO synchroniser, a sticky switch-change flag and a cycle counter, and it flags out-of-range accesses. It sits between the pipeline MEM stage (port A, read/write) and a read-only fetch or DMA path (port B).

Parameters:
DATA_W, 24, data word width
ADDR_W, 19, word-address width
IO_WORDS, 76, size of the IO region starting at address 0
MEM_DEPTH, 4096, main RAM depth in words; mapped at IO_WORDS..IO_WORDS+MEM_DEPTH-1
SW_W, 4, switch input width
GPIO_W, 36, GPIO input and output width

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
a_req  in  1  port A access request
a_we  in  1  port A write enable; qualified by a_req
a_addr  in  ADDR_W  port A word address
a_wdata  in  DATA_W  port A write data
a_rvalid  out  1  port A read data valid, one cycle after a read request
a_rdata  out  DATA_W  port A read data
a_err  out  1  one-cycle pulse, one cycle after an out-of-range or illegal access on port A
b_req  in  1  port B read request
b_addr  in  ADDR_W  port B word address
b_rvalid  out  1  port B read data valid
b_rdata  out  DATA_W  port B read data
b_err  out  1  port B out-of-range pulse
switches  in  SW_W  asynchronous switch inputs
gpio_in  in  GPIO_W  asynchronous GPIO inputs
gpio_out  out  GPIO_W  registered GPIO outputs

Behaviour:
- Reset (rst=0, asynchronous): a_rvalid, b_rvalid, a_err, b_err, a_rdata, b_rdata, gpio_out, sync flops, chg flag and cycle counter all clear to 0. RAM contents are not reset.
- Decode, per port:
  - addr < IO_WORDS: IO region
  - IO_WORDS <= addr < IO_WORDS+MEM_DEPTH: RAM, index = addr - IO_WORDS
  - anything else: out of range
- Latency: a read accepted in cycle N gives rvalid=1 and rdata valid in cycle N+1. Writes commit at the edge ending cycle N. A write never raises a_rvalid. Requests are accepted every cycle, with no backpressure.
- Out-of-range access:
  - read: rvalid=1, rdata=0, err=1 in N+1
  - write: dropped, a_err=1 in N+1
- IO map. Word offsets are in the shared package. Fields narrower than DATA_W are zero-extended; GPIO_W wider than DATA_W is split across LO/HI words.
  - 0 SW: 2-flop synchronised switches, read-only
  - 1 GPIN_LO, 2 GPIN_HI: 2-flop synchronised gpio_in, read-only
  - 3 GPOUT_LO, 4 GPOUT_HI: read/write; drive gpio_out
  - 5 SWCHG: bit0 is sticky and sets when the synchronised switches differ from their previous cycle. Any write clears it. A set event and a clearing write in the same cycle leave it set.
  - 6 CYCLES: free-running DATA_W counter, wraps from all-ones to 0, read-only
  - 7..IO_WORDS-1: read 0; writes ignored with no error
- Writes to read-only IO words: ignored, a_err pulse.
- Port B:
  - read-only, with identical decode
  - port B reading the IO region is legal
- Collision: a port A RAM write and a port B read of the same RAM index in the same cycle make b_rdata return the new write data (write-first forwarding). A port A read-write on the same port returns the old data, because the read and write cannot be requested together.
- Reset asserted mid-operation: pending rvalid/err are cancelled immediately. There is no replay.

Decomposition:
- Package dmem_pkg holds:
  - IO offset localparams (IO_SW, IO_GPIN_LO, IO_GPIN_HI, IO_GPOUT_LO, IO_GPOUT_HI, IO_SWCHG, IO_CYCLES)
  - an enum region_e {REG_IO, REG_RAM, REG_OOR}
  - a decode function taking addr, IO_WORDS and MEM_DEPTH
- One sub-module, dmem_io_regs, contains the synchronisers, GPOUT registers, SWCHG flag, counter and IO read mux. The top level holds the RAM array, decode, forwarding and output pipeline registers.

Test Plan:
- Reset, then a_req write 0x123456 to addr 76; next cycle read addr 76 -> a_rvalid=1, a_rdata=0x123456 exactly one cycle after the read; a_err=0.
- Write addr 4171 (last RAM word at defaults), then read addr 4172 -> 4171 returns the data; 4172 gives a_rvalid=1, a_rdata=0, a_err=1; a write to 4172 gives a_err=1 and leaves RAM unchanged.
- Same-cycle port A write 0xABCDEF to addr 100 and port B read of addr 100 -> b_rdata=0xABCDEF next cycle.
- Write 0xFFFFFF to GPOUT_LO and 0x000FFF to GPOUT_HI -> gpio_out=36'hFFFFFFFFF. Write to SW -> a_err=1, no state change.
- Toggle switches 0->4'b1010 -> SW reads 0xA after 2 cycles of sync; SWCHG bit0=1. Write SWCHG -> reads 0. Toggle again in the same cycle as the write -> stays 1.
- Assert rst low mid-stream after a read request -> a_rvalid stays 0, gpio_out=0, CYCLES restarts at 0 after release.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: IO word offsets, region type and address decode shared by the data-memory controller.
package dmem_pkg;
    localparam int unsigned IO_SW       = 0;
    localparam int unsigned IO_GPIN_LO  = 1;
    localparam int unsigned IO_GPIN_HI  = 2;
    localparam int unsigned IO_GPOUT_LO = 3;
    localparam int unsigned IO_GPOUT_HI = 4;
    localparam int unsigned IO_SWCHG    = 5;
    localparam int unsigned IO_CYCLES   = 6;

    typedef enum logic [1:0] {REG_IO, REG_RAM, REG_OOR} region_e;

    function automatic region_e decode(input logic [31:0] addr, input int unsigned io_words,
                                       input int unsigned mem_depth);
        return addr < io_words ? REG_IO : (addr < io_words + mem_depth ? REG_RAM : REG_OOR);
    endfunction
endpackage

// File: rtl/dmem_io_regs.sv
// dmem_io_regs: switch/GPIO synchronisers, GPIO output registers, sticky switch-change flag, cycle counter and IO read mux.
module dmem_io_regs import dmem_pkg::*; #(
    parameter int DATA_W = 24,
    parameter int SW_W   = 4,
    parameter int GPIO_W = 36,
    parameter int OW     = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SW_W-1:0]   switches_i,
    input  logic [GPIO_W-1:0] gpio_in_i,
    input  logic              we_i,
    input  logic [OW-1:0]     a_off_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [OW-1:0]     b_off_i,
    output logic [DATA_W-1:0] a_rdata_o,
    output logic [DATA_W-1:0] b_rdata_o,
    output logic [GPIO_W-1:0] gpio_out_o
);
    logic [SW_W-1:0]   sw_s1_q, sw_s2_q, sw_prev_q;
    logic [GPIO_W-1:0] gpin_s1_q, gpin_s2_q, gpout_q, gpout_d;
    logic              chg_q, chg_d;
    logic [DATA_W-1:0] cyc_q;
    logic [DATA_W-1:0] words [8];

    always_comb begin
        gpout_d = gpout_q;
        if (we_i && a_off_i == OW'(IO_GPOUT_LO)) gpout_d[DATA_W-1:0] = wdata_i;
        if (we_i && a_off_i == OW'(IO_GPOUT_HI)) gpout_d[GPIO_W-1:DATA_W] = wdata_i[GPIO_W-DATA_W-1:0];
        // a change event wins over a clearing write in the same cycle
        chg_d = (sw_s2_q != sw_prev_q) || (chg_q && !(we_i && a_off_i == OW'(IO_SWCHG)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            sw_prev_q <= '0;
            gpin_s1_q <= '0;
            gpin_s2_q <= '0;
            gpout_q   <= '0;
            chg_q     <= 1'b0;
            cyc_q     <= '0;
        end else begin
            sw_s1_q   <= switches_i;
            sw_s2_q   <= sw_s1_q;
            sw_prev_q <= sw_s2_q;
            gpin_s1_q <= gpio_in_i;
            gpin_s2_q <= gpin_s1_q;
            gpout_q   <= gpout_d;
            chg_q     <= chg_d;
            cyc_q     <= cyc_q + DATA_W'(1);
        end
    end

    assign words[IO_SW]       = DATA_W'(sw_s2_q);
    assign words[IO_GPIN_LO]  = gpin_s2_q[DATA_W-1:0];
    assign words[IO_GPIN_HI]  = DATA_W'(gpin_s2_q >> DATA_W);
    assign words[IO_GPOUT_LO] = gpout_q[DATA_W-1:0];
    assign words[IO_GPOUT_HI] = DATA_W'(gpout_q >> DATA_W);
    assign words[IO_SWCHG]    = DATA_W'(chg_q);
    assign words[IO_CYCLES]   = cyc_q;
    assign words[7]           = '0;

    assign a_rdata_o  = a_off_i[OW-1:3] == '0 ? words[a_off_i[2:0]] : '0;
    assign b_rdata_o  = b_off_i[OW-1:3] == '0 ? words[b_off_i[2:0]] : '0;
    assign gpio_out_o = gpout_q;
endmodule

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: two-port data memory with IO/RAM address map, registered reads and write-first port B forwarding.
module data_memory_ctrl import dmem_pkg::*; #(
    parameter int DATA_W    = 24,
    parameter int ADDR_W    = 19,
    parameter int IO_WORDS  = 76,
    parameter int MEM_DEPTH = 4096,
    parameter int SW_W      = 4,
    parameter int GPIO_W    = 36
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,
    input  logic [SW_W-1:0]   switches,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int OW = $clog2(IO_WORDS);

    region_e           a_reg, b_reg;
    logic [AW-1:0]     a_idx, b_idx;
    logic [OW-1:0]     a_off, b_off;
    logic              a_ro, a_wr_ram, b_fwd;
    logic [DATA_W-1:0] io_a_rdata, io_b_rdata;
    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    logic              a_rvalid_q, a_rvalid_d, a_err_q, a_err_d;
    logic              b_rvalid_q, b_rvalid_d, b_err_q, b_err_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

    assign a_reg    = decode(32'(a_addr), IO_WORDS, MEM_DEPTH);
    assign b_reg    = decode(32'(b_addr), IO_WORDS, MEM_DEPTH);
    assign a_idx    = AW'(a_addr - ADDR_W'(IO_WORDS));
    assign b_idx    = AW'(b_addr - ADDR_W'(IO_WORDS));
    assign a_off    = OW'(a_addr);
    assign b_off    = OW'(b_addr);
    assign a_ro     = a_off == OW'(IO_SW) || a_off == OW'(IO_GPIN_LO) ||
                      a_off == OW'(IO_GPIN_HI) || a_off == OW'(IO_CYCLES);
    assign a_wr_ram = a_req && a_we && a_reg == REG_RAM;
    assign b_fwd    = a_wr_ram && b_reg == REG_RAM && a_idx == b_idx;

    always_comb begin
        a_rvalid_d = a_req && !a_we;
        a_err_d    = a_req && (a_reg == REG_OOR || (a_we && a_reg == REG_IO && a_ro));
        a_rdata_d  = !a_rvalid_d ? a_rdata_q : a_reg == REG_RAM ? mem_q[a_idx] :
                     a_reg == REG_IO ? io_a_rdata : '0;
        b_rvalid_d = b_req;
        b_err_d    = b_req && b_reg == REG_OOR;
        b_rdata_d  = !b_req ? b_rdata_q : b_reg == REG_RAM ? (b_fwd ? a_wdata : mem_q[b_idx]) :
                     b_reg == REG_IO ? io_b_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (a_wr_ram) mem_q[a_idx] <= a_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_rvalid_q <= 1'b0;
            a_err_q    <= 1'b0;
            a_rdata_q  <= '0;
            b_rvalid_q <= 1'b0;
            b_err_q    <= 1'b0;
            b_rdata_q  <= '0;
        end else begin
            a_rvalid_q <= a_rvalid_d;
            a_err_q    <= a_err_d;
            a_rdata_q  <= a_rdata_d;
            b_rvalid_q <= b_rvalid_d;
            b_err_q    <= b_err_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    dmem_io_regs #(.DATA_W(DATA_W), .SW_W(SW_W), .GPIO_W(GPIO_W), .OW(OW)) u_io (
        .clk        (clk),
        .rst        (rst),
        .switches_i (switches),
        .gpio_in_i  (gpio_in),
        .we_i       (a_req && a_we && a_reg == REG_IO),
        .a_off_i    (a_off),
        .wdata_i    (a_wdata),
        .b_off_i    (b_off),
        .a_rdata_o  (io_a_rdata),
        .b_rdata_o  (io_b_rdata),
        .gpio_out_o (gpio_out)
    );

    assign a_rvalid = a_rvalid_q;
    assign a_err    = a_err_q;
    assign a_rdata  = a_rdata_q;
    assign b_rvalid = b_rvalid_q;
    assign b_err    = b_err_q;
    assign b_rdata  = b_rdata_q;
endmodule
